// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MDU_ITERS = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One shift-add multiply or restoring shift-subtract divide iteration.
module mdu_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] work,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] work_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, acc} + (work[0] ? {1'b0, opnd} : '0);
    shifted = {acc, work[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    if (is_div) begin
      // Bit WIDTH of diff is the borrow: set means the partial remainder is below the divisor.
      if (!diff[WIDTH]) begin
        acc_next  = diff[WIDTH-1:0];
        work_next = {work[WIDTH-2:0], 1'b1};
      end else begin
        acc_next  = shifted[WIDTH-1:0];
        work_next = {work[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next  = sum[WIDTH:1];
      work_next = {sum[0], work[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative MIPS multiply/divide unit with HI/LO registers: FSM, counter, sign
// bookkeeping and result fix-up around the mdu_step datapath.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned ITERS = WIDTH;
  localparam int unsigned CW    = $clog2(ITERS);

  mdu_state_e       state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] acc_q, work_q, opnd_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             is_div_q, neg_q, rem_neg_q, div_zero_q, done_q;

  mdu_op_e          op_e;
  logic             sgn, is_div_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] acc_n, work_n;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quot, rem, res_hi, res_lo;

  always_comb begin
    op_e      = mdu_op_e'(op);
    sgn       = op_is_signed(op_e);
    is_div_op = (op_e == MDU_DIV) || (op_e == MDU_DIVU);
    a_neg     = sgn && a[WIDTH-1];
    b_neg     = sgn && b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
  end

  mdu_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div    (is_div_q),
    .acc       (acc_q),
    .work      (work_q),
    .opnd      (opnd_q),
    .acc_next  (acc_n),
    .work_next (work_n)
  );

  // Final fix-up applied to the last step's outputs on the completing edge.
  always_comb begin
    prod = {acc_n, work_n};
    if (neg_q) prod = -prod;
    quot = neg_q ? -work_n : work_n;
    rem  = rem_neg_q ? -acc_n : acc_n;
    if (div_zero_q) quot = '1;
    res_hi = is_div_q ? rem  : prod[2*WIDTH-1:WIDTH];
    res_lo = is_div_q ? quot : prod[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      work_q     <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && !flush) begin
            unique case (op_e)
              MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                state_q    <= RUN;
                count_q    <= '0;
                acc_q      <= '0;
                is_div_q   <= is_div_op;
                work_q     <= is_div_op ? a_mag : b_mag;
                opnd_q     <= is_div_op ? b_mag : a_mag;
                neg_q      <= a_neg ^ b_neg;
                rem_neg_q  <= is_div_op && a_neg;
                div_zero_q <= is_div_op && (b == '0);
              end
              MDU_MTHI: hi_q <= a;
              MDU_MTLO: lo_q <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            acc_q   <= acc_n;
            work_q  <= work_n;
            count_q <= count_q + 1'b1;
            if (count_q == CW'(ITERS - 1)) begin
              hi_q    <= res_hi;
              lo_q    <= res_lo;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed cases plus random ops vs. an arithmetic model.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_hi, exp_lo;

  always #5 clk = ~clk;

  mdu_hilo #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Architectural result {hi,lo} of one op given current {hi,lo}.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, y,
                                        input logic [63:0] cur);
    longint sx, sy, q, r;
    logic [63:0] res;
    res = cur;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    case (o)
      3'd0: res = sx * sy;
      3'd1: res = {32'd0, x} * {32'd0, y};
      3'd2: if (y == 0) res = {x, 32'hFFFF_FFFF};
            else begin q = sx / sy; r = sx % sy; res = {r[31:0], q[31:0]}; end
      3'd3: if (y == 0) res = {x, 32'hFFFF_FFFF};
            else res = {x % y, x / y};
      3'd4: res = {x, cur[31:0]};
      3'd5: res = {cur[63:32], x};
      default: ;
    endcase
    return res;
  endfunction

  // Issue one op and wait (bounded) until idle; no checking here.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, y, output int cyc,
                        output logic dn, output logic [31:0] h, l, output logic dn_after);
    @(negedge clk); start = 1'b1; op = o; a = x; b = y;
    @(negedge clk); start = 1'b0; a = $urandom; b = $urandom;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin cyc++; @(negedge clk); end
    dn = done; h = hi; l = lo;
    @(negedge clk); dn_after = done;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    rst = 1'b1;
    exp_hi = '0; exp_lo = '0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [2:0]  ops [6] = '{3'd0, 3'd1, 3'd5, 3'd2, 3'd2, 3'd3};
    logic [31:0] as  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFF9,
                            32'h8000_0000, 32'h0000_1234};
    logic [31:0] bs  [6] = '{32'd5, 32'hFFFF_FFFF, 32'd0, 32'd2, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] eh  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                            32'h0, 32'h0000_1234};
    logic [31:0] el  [6] = '{32'hFFFF_FFF1, 32'h1, 32'h1234_5678, 32'hFFFF_FFFD,
                            32'h8000_0000, 32'hFFFF_FFFF};
    int cyc; logic dn, dn2; logic [31:0] h, l;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], cyc, dn, h, l, dn2);
      checks++; if (h !== eh[i] || l !== el[i]) begin failures++;
        $display("FAIL directed%0d_hilo got=%h_%h exp=%h_%h", i, h, l, eh[i], el[i]); end
      checks++; if (cyc !== (ops[i] < 4 ? 32 : 0)) begin failures++;
        $display("FAIL directed%0d_busy_cycles got=%0d exp=%0d", i, cyc, ops[i] < 4 ? 32 : 0); end
      checks++; if (dn !== (ops[i] < 4)) begin failures++;
        $display("FAIL directed%0d_done got=%b exp=%b", i, dn, ops[i] < 4); end
      checks++; if (dn2 !== 1'b0) begin failures++;
        $display("FAIL directed%0d_done_width got=%b exp=0", i, dn2); end
      exp_hi = eh[i]; exp_lo = el[i];
    end
  endtask

  task automatic test_flush;
    int seen;
    @(negedge clk); start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd9;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
    seen = 0;
    repeat (40) begin if (done === 1'b1) seen++; @(negedge clk); end
    checks++; if (seen !== 0) begin failures++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
    checks++; if (hi !== exp_hi || lo !== exp_lo) begin failures++;
      $display("FAIL flush_hilo got=%h_%h exp=%h_%h", hi, lo, exp_hi, exp_lo); end
    // Flush wins over a same-cycle start in IDLE.
    flush = 1'b1; start = 1'b1; op = 3'd4; a = ~exp_hi;
    @(negedge clk); flush = 1'b0; start = 1'b0;
    checks++; if (hi !== exp_hi || busy !== 1'b0) begin failures++;
      $display("FAIL flush_idle_drop got=%h busy=%b exp=%h busy=0", hi, busy, exp_hi); end
  endtask

  task automatic test_start_during_run;
    logic [31:0] x, y; logic [63:0] e; int cyc;
    x = $urandom; y = $urandom;
    e = model(3'd1, x, y, {exp_hi, exp_lo});
    @(negedge clk); start = 1'b1; op = 3'd1; a = x; b = y;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    repeat (4) begin @(negedge clk); cyc++; end
    start = 1'b1; op = 3'd5; a = $urandom;
    @(negedge clk); cyc++; op = 3'd2; b = 32'd3;
    @(negedge clk); cyc++; start = 1'b0;
    while (busy === 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    checks++; if (cyc !== 33) begin failures++;
      $display("FAIL busy_start_cycles got=%0d exp=33", cyc); end
    checks++; if ({hi, lo} !== e) begin failures++;
      $display("FAIL busy_start_result got=%h_%h exp=%h", hi, lo, e); end
    exp_hi = e[63:32]; exp_lo = e[31:0];
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk); start = 1'b1; op = 3'd3; a = 32'hDEAD_BEEF; b = 32'd17;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (hi !== 0 || lo !== 0 || busy !== 1'b0) begin failures++;
      $display("FAIL reset_mid got=%h_%h busy=%b exp=0_0 busy=0", hi, lo, busy); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (40) begin if (done === 1'b1 || busy === 1'b1) seen++; @(negedge clk); end
    checks++; if (seen !== 0 || hi !== 0 || lo !== 0) begin failures++;
      $display("FAIL reset_mid_after got=%0d %h_%h exp=0 0_0", seen, hi, lo); end
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_random;
    logic [2:0] o; logic [31:0] x, y; logic [63:0] e;
    int cyc; logic dn, dn2; logic [31:0] h, l;
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom; y = $urandom;
      if ($urandom_range(0, 5) == 0) y = 32'd0;
      if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(0, 31);
      e = model(o, x, y, {exp_hi, exp_lo});
      run_op(o, x, y, cyc, dn, h, l, dn2);
      checks++; if ({h, l} !== e || dn !== (o < 4) || cyc !== (o < 4 ? 32 : 0)) begin
        failures++;
        $display("FAIL random%0d op=%0d a=%h b=%h got=%h_%h done=%b cyc=%0d exp=%h done=%b",
                 i, o, x, y, h, l, dn, cyc, e, o < 4);
      end
      exp_hi = e[63:32]; exp_lo = e[31:0];
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_start_during_run();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
